sqm_run_unit: RTL and testbench

Multi-cycle, parametrised successor to the team's combinational square-mod / ones-run block. Accepts one operation per start handshake: either B² mod A via restoring division, or the adjacent-bit mux mapping of B under A. It then reports the result word and the length of its longest circular run of ones. It sits beside the ALU as a slow co-processor: one operation in flight, start/busy/done handshake, results held until the next accepted start.

---
 rtl/sqm_run_unit_if.sv | 33 +++
 rtl/sqm_run_unit.sv | 215 +++++++++++++++++++++
 tb/tb_sqm_run_unit.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqm_run_unit_if.sv
// sqm_run_unit_if: request/response bundle for the sqm_run_unit co-processor.
//   start, op, a, b : request side, driven by the master (ALU / sequencer).
//   busy, done      : status, driven by the slave (the unit).
//   y, c, z, err    : result words, held by the slave until the next DONE.
// Parameters: W = data width of a/y (>= 2), S = mux select width (b is 2**S bits).
interface sqm_run_unit_if #(
    parameter int unsigned W = 8,
    parameter int unsigned S = 2
);
    localparam int unsigned BW = 1 << S;
    localparam int unsigned ZW = $clog2(W + 1);

    logic              start;
    logic              op;
    logic [W-1:0]      a;
    logic [BW-1:0]     b;
    logic              busy;
    logic              done;
    logic [W-1:0]      y;
    logic [2*BW-1:0]   c;
    logic [ZW-1:0]     z;
    logic              err;

    modport master (
        output start, op, a, b,
        input  busy, done, y, c, z, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, y, c, z, err
    );
endinterface

// File: rtl/sqm_run_unit.sv
// sqm_run_unit: multi-cycle square-mod / mux-map unit with longest circular run-of-ones count.
//   clk   : rising-edge clock.
//   reset : asynchronous, active-high; returns to IDLE with all outputs cleared.
//   bus   : sqm_run_unit_if slave modport.
//     start/op/a/b sampled in IDLE or DONE. op=1: y = (b*b) mod a, c = b*b, err if a==0.
//     op=0: y[i] = b[{a[(i+S-1)%W], ..., a[i]}], c = 0.
//     z = longest circular run of ones in y. busy in MAP/DIV/SCAN, done pulses in DONE.
//     y/c/z/err change only on entry to DONE (or on reset).
module sqm_run_unit #(
    parameter int unsigned W = 8,
    parameter int unsigned S = 2
) (
    input logic           clk,
    input logic           reset,
    sqm_run_unit_if.slave bus
);
    localparam int unsigned BW = 1 << S;
    localparam int unsigned CW = 2 * BW;
    localparam int unsigned ZW = $clog2(W + 1);
    // Run counter spans two laps of y, so it can reach 2W before clamping.
    localparam int unsigned RW = $clog2(2 * W + 1);
    localparam int unsigned NMAX = (CW > 2 * W) ? CW : 2 * W;
    localparam int unsigned NW = $clog2(NMAX + 1);

    typedef enum logic [2:0] {
        StIdle,
        StMap,
        StDiv,
        StScan,
        StDone
    } state_e;

    state_e          state_q, state_d;

    // Latched request.
    logic [W-1:0]    a_q, a_d;
    logic [BW-1:0]   b_q, b_d;

    // Working registers.
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   dvd_q, dvd_d;
    logic [W:0]      rem_q, rem_d;
    logic [W-1:0]    yw_q, yw_d;
    logic [CW-1:0]   cw_q, cw_d;
    logic            errw_q, errw_d;
    logic [RW-1:0]   run_q, run_d;
    logic [RW-1:0]   max_q, max_d;

    // Held outputs.
    logic [W-1:0]    y_q, y_d;
    logic [CW-1:0]   c_q, c_d;
    logic [ZW-1:0]   z_q, z_d;
    logic            err_q, err_d;

    // Datapath helpers.
    logic [CW-1:0]   bsq;
    logic [W-1:0]    map_y;
    logic [W:0]      rem_sh;
    logic [W:0]      rem_next;
    logic [W-1:0]    yw_rot;
    logic [RW-1:0]   run_next;
    logic [RW-1:0]   max_next;
    logic [ZW-1:0]   z_fin;

    assign bsq = CW'(bus.b) * CW'(bus.b);

    // Adjacent-bit mux map: select bit j of output i comes from a[(i+j) mod W].
    always_comb begin
        map_y = '0;
        for (int i = 0; i < W; i++) begin
            logic [S-1:0] sel;
            sel = '0;
            for (int j = 0; j < S; j++) begin
                sel[j] = a_q[(i + j) % W];
            end
            map_y[i] = b_q[sel];
        end
    end

    // One restoring-division step: shift in next dividend bit, subtract if it fits.
    assign rem_sh   = {rem_q[W-1:0], dvd_q[CW-1]};
    assign rem_next = (rem_sh >= {1'b0, a_q}) ? (rem_sh - {1'b0, a_q}) : rem_sh;

    // Scan rotates the working word right each cycle and looks at bit 0; after 2W
    // rotations the word is back to its original value.
    assign yw_rot   = {yw_q[0], yw_q[W-1:1]};
    assign run_next = yw_q[0] ? (run_q + RW'(1)) : '0;
    assign max_next = (run_next > max_q) ? run_next : max_q;
    assign z_fin    = (max_next > RW'(W)) ? ZW'(W) : max_next[ZW-1:0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        yw_d    = yw_q;
        cw_d    = cw_q;
        errw_d  = errw_q;
        run_d   = run_q;
        max_d   = max_q;
        y_d     = y_q;
        c_d     = c_q;
        z_d     = z_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    cnt_d = '0;
                    run_d = '0;
                    max_d = '0;
                    rem_d = '0;
                    if (bus.op) begin
                        cw_d   = bsq;
                        dvd_d  = bsq;
                        errw_d = (bus.a == '0);
                        if (bus.a == '0) begin
                            // Division by zero: skip straight to scanning a zero result.
                            yw_d    = '0;
                            state_d = StScan;
                        end else begin
                            state_d = StDiv;
                        end
                    end else begin
                        cw_d    = '0;
                        errw_d  = 1'b0;
                        state_d = StMap;
                    end
                end
            end

            StMap: begin
                yw_d    = map_y;
                cnt_d   = '0;
                state_d = StScan;
            end

            StDiv: begin
                rem_d = rem_next;
                dvd_d = {dvd_q[CW-2:0], 1'b0};
                cnt_d = cnt_q + NW'(1);
                if (cnt_q == NW'(CW - 1)) begin
                    yw_d    = rem_next[W-1:0];
                    cnt_d   = '0;
                    state_d = StScan;
                end
            end

            StScan: begin
                yw_d  = yw_rot;
                run_d = run_next;
                max_d = max_next;
                cnt_d = cnt_q + NW'(1);
                if (cnt_q == NW'(2 * W - 1)) begin
                    // Last scan step: yw_rot has completed 2W rotations.
                    y_d     = yw_rot;
                    c_d     = cw_q;
                    z_d     = z_fin;
                    err_d   = errw_q;
                    state_d = StDone;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            yw_q    <= '0;
            cw_q    <= '0;
            errw_q  <= 1'b0;
            run_q   <= '0;
            max_q   <= '0;
            y_q     <= '0;
            c_q     <= '0;
            z_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            yw_q    <= yw_d;
            cw_q    <= cw_d;
            errw_q  <= errw_d;
            run_q   <= run_d;
            max_q   <= max_d;
            y_q     <= y_d;
            c_q     <= c_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy = (state_q == StMap) || (state_q == StDiv) || (state_q == StScan);
    assign bus.done = (state_q == StDone);
    assign bus.y    = y_q;
    assign bus.c    = c_q;
    assign bus.z    = z_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_sqm_run_unit.sv
module tb_sqm_run_unit;
    localparam int unsigned W  = 8;
    localparam int unsigned S  = 2;
    localparam int unsigned BW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sqm_run_unit_if #(.W(W), .S(S)) bus ();

    sqm_run_unit #(.W(W), .S(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model_y(input logic op, input logic [W-1:0] a,
                                             input logic [BW-1:0] b);
        logic [W-1:0] y;
        if (op) begin
            if (a == 0) return '0;
            return W'((int'(b) * int'(b)) % int'(a));
        end
        y = '0;
        for (int i = 0; i < W; i++) begin
            int idx;
            idx = 0;
            for (int j = 0; j < S; j++)
                if (a[(i + j) % W]) idx += (1 << j);
            y[i] = b[idx];
        end
        return y;
    endfunction

    function automatic int model_z(input logic [W-1:0] y);
        int best, run;
        best = 0;
        run  = 0;
        for (int k = 0; k < 2 * W; k++) begin
            run = y[k % W] ? run + 1 : 0;
            if (run > best) best = run;
        end
        return (best > W) ? W : best;
    endfunction

    function automatic int model_c(input logic op, input logic [BW-1:0] b);
        return op ? int'(b) * int'(b) : 0;
    endfunction

    function automatic int model_lat(input logic op, input logic [W-1:0] a);
        if (!op) return 2 * W + 2;
        if (a == 0) return 2 * W + 1;
        return 2 * BW + 2 * W + 1;
    endfunction

    // ---------------- drivers ----------------
    task automatic go(input logic op, input logic [W-1:0] a, input logic [BW-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Returns the cycle (relative to the accepting edge) in which done was seen, or -1.
    task automatic wait_done(output int lat, output logic busy1);
        lat   = -1;
        busy1 = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) busy1 = bus.busy;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.y, bus.c, bus.z, bus.err} !== '0) begin
            bad++;
            $display("FAIL reset_values: got busy=%b done=%b y=%h c=%h z=%0d err=%b want all 0",
                     bus.busy, bus.done, bus.y, bus.c, bus.z, bus.err);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_sqmod();
        logic [W-1:0] a;
        logic [BW-1:0] b;
        int lat;
        logic busy1;
        for (int t = 0; t < 16; t++) begin
            if (t == 0) begin
                a = 8'd7;
                b = 4'd5;
            end else begin
                a = W'($urandom_range(1, (1 << W) - 1));
                b = BW'($urandom);
            end
            go(1'b1, a, b);
            wait_done(lat, busy1);
            total++;
            if (lat != model_lat(1'b1, a)) begin
                bad++;
                $display("FAIL sqmod_latency a=%0d b=%0d: got %0d want %0d", a, b, lat,
                         model_lat(1'b1, a));
            end
            total++;
            if (busy1 !== 1'b1 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL sqmod_busy: got cycle1=%b done_cycle=%b want 1 0", busy1, bus.busy);
            end
            total++;
            if (bus.y !== model_y(1'b1, a, b) || int'(bus.c) != model_c(1'b1, b) ||
                int'(bus.z) != model_z(model_y(1'b1, a, b)) || bus.err !== 1'b0) begin
                bad++;
                $display("FAIL sqmod_result a=%0d b=%0d: got y=%h c=%0d z=%0d err=%b want y=%h c=%0d z=%0d err=0",
                         a, b, bus.y, bus.c, bus.z, bus.err, model_y(1'b1, a, b),
                         model_c(1'b1, b), model_z(model_y(1'b1, a, b)));
            end
        end
    endtask

    task automatic test_map();
        logic [W-1:0] a;
        logic [BW-1:0] b;
        logic [W-1:0] ey;
        int lat;
        logic busy1;
        for (int t = 0; t < 16; t++) begin
            if (t == 0) begin
                a = 8'h00;
                b = 4'b0001;
            end else if (t == 1) begin
                a = 8'h87;
                b = 4'b1000;
            end else begin
                a = W'($urandom);
                b = BW'($urandom);
            end
            ey = model_y(1'b0, a, b);
            go(1'b0, a, b);
            wait_done(lat, busy1);
            total++;
            if (lat != model_lat(1'b0, a) || busy1 !== 1'b1) begin
                bad++;
                $display("FAIL map_latency a=%h b=%b: got %0d busy1=%b want %0d busy1=1",
                         a, b, lat, busy1, model_lat(1'b0, a));
            end
            total++;
            if (bus.y !== ey || bus.c !== '0 || int'(bus.z) != model_z(ey) || bus.err !== 1'b0) begin
                bad++;
                $display("FAIL map_result a=%h b=%b: got y=%h c=%h z=%0d err=%b want y=%h c=0 z=%0d err=0",
                         a, b, bus.y, bus.c, bus.z, bus.err, ey, model_z(ey));
            end
            // Outputs must hold through IDLE.
            repeat (3) @(negedge clk);
            total++;
            if (bus.y !== ey || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL map_hold: got y=%h done=%b busy=%b want y=%h done=0 busy=0",
                         bus.y, bus.done, bus.busy, ey);
            end
        end
    endtask

    task automatic test_err();
        int lat;
        logic busy1;
        go(1'b1, 8'd0, 4'd9);
        wait_done(lat, busy1);
        total++;
        if (lat != 17 || bus.y !== 8'h00 || bus.c !== 8'd81 || bus.z !== 4'd0 ||
            bus.err !== 1'b1) begin
            bad++;
            $display("FAIL err_divzero: got lat=%0d y=%h c=%0d z=%0d err=%b want 17 00 81 0 1",
                     lat, bus.y, bus.c, bus.z, bus.err);
        end
        go(1'b1, 8'd7, 4'd5);
        wait_done(lat, busy1);
        total++;
        if (lat != 25 || bus.y !== 8'h04 || bus.c !== 8'd25 || bus.z !== 4'd1 ||
            bus.err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: got lat=%0d y=%h c=%0d z=%0d err=%b want 25 04 25 1 0",
                     lat, bus.y, bus.c, bus.z, bus.err);
        end
    endtask

    task automatic test_busy_ignore();
        int ndone, lat;
        logic [W-1:0] ycap;
        ndone = 0;
        lat   = -1;
        ycap  = '0;
        go(1'b1, 8'd11, 4'd15);
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 5) begin
                bus.start = 1'b1;
                bus.op    = 1'b0;
                bus.a     = 8'hFF;
                bus.b     = 4'hF;
            end
            if (n == 6) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat  = n;
                    ycap = bus.y;
                end
            end
        end
        total++;
        if (ndone != 1 || lat != 25 || ycap !== 8'd5) begin
            bad++;
            $display("FAIL busy_ignore: got dones=%0d lat=%0d y=%h want 1 25 05", ndone, lat, ycap);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic busy1;
        go(1'b0, 8'h87, 4'b1000);
        wait_done(lat, busy1);
        total++;
        if (lat != 18 || bus.y !== 8'h83 || bus.z !== 4'd3) begin
            bad++;
            $display("FAIL b2b_first: got lat=%0d y=%h z=%0d want 18 83 3", lat, bus.y, bus.z);
        end
        // Issue the next start during the DONE cycle itself.
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 8'd7;
        bus.b     = 4'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, busy1);
        total++;
        if (lat != 25 || busy1 !== 1'b1 || bus.y !== 8'h04 || bus.c !== 8'd25 || bus.z !== 4'd1) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d busy1=%b y=%h c=%0d z=%0d want 25 1 04 25 1",
                     lat, busy1, bus.y, bus.c, bus.z);
        end
    endtask

    task automatic test_reset_mid();
        int lat, ndone;
        logic busy1;
        ndone = 0;
        // Leave nonzero held outputs behind first.
        go(1'b1, 8'd0, 4'd9);
        wait_done(lat, busy1);
        go(1'b1, 8'd7, 4'd5);
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.y, bus.c, bus.z, bus.err} !== '0) begin
            bad++;
            $display("FAIL reset_mid_async: got busy=%b done=%b y=%h c=%h z=%0d err=%b want all 0",
                     bus.busy, bus.done, bus.y, bus.c, bus.z, bus.err);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        reset = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL reset_mid_nodone: got %0d done pulses want 0", ndone);
        end
        go(1'b1, 8'd13, 4'd12);
        wait_done(lat, busy1);
        total++;
        if (lat != 25 || bus.y !== 8'd1 || bus.c !== 8'd144 || bus.z !== 4'd1 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_recover: got lat=%0d y=%h c=%0d z=%0d err=%b want 25 01 144 1 0",
                     lat, bus.y, bus.c, bus.z, bus.err);
        end
    endtask

    initial begin
        test_reset();
        test_sqmod();
        test_map();
        test_err();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
